cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.

---
 rtl/cla_pipe_adder_if.sv | 27 ++
 rtl/cla_pipe_adder.sv | 193 +++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master drives operands and consumes results; the slave is the adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_MID_REG_EN to register between the lookahead levels (latency 2, otherwise 1).
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic           clock,
    input  logic           reset,
    cla_pipe_adder_if.slave bus
);
    localparam int NGRP = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || NGRP < 1) begin : g_bad_geometry
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic             in_ready;
    logic             s1_adv;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // First lookahead level: effective operands, bit and group propagate/generate.
    logic [WIDTH-1:0] bp_l1, p_l1, g_l1;
    logic             c0_l1;
    logic [NGRP-1:0]  gp_l1, gg_l1;

    always_comb begin
        bp_l1 = bus.sub ? ~bus.b : bus.b;
        c0_l1 = bus.sub | bus.cin;
        p_l1  = bus.a | bp_l1;
        g_l1  = bus.a & bp_l1;
        gp_l1 = '1;
        gg_l1 = '0;
        for (int k = 0; k < NGRP; k++) begin
            for (int i = 0; i < BLOCK; i++) begin
                gg_l1[k] = g_l1[k*BLOCK+i] | (p_l1[k*BLOCK+i] & gg_l1[k]);
                gp_l1[k] = gp_l1[k] & p_l1[k*BLOCK+i];
            end
        end
    end

    logic             l2_valid;
    logic [WIDTH-1:0] l2_a, l2_bp, l2_p, l2_g;
    logic             l2_c0;
    logic [NGRP-1:0]  l2_gp, l2_gg;

    assign s1_adv = ~out_valid_q | bus.out_ready;

`ifdef CLA_MID_REG_EN
    logic             s1_valid_q, s1_valid_d;
    logic             s1_c0_q, s1_c0_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_bp_q, s1_bp_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d, s1_g_q, s1_g_d;
    logic [NGRP-1:0]  s1_gp_q, s1_gp_d, s1_gg_q, s1_gg_d;

    assign in_ready = ~s1_valid_q | s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_c0_d    = s1_c0_q;
        s1_a_d     = s1_a_q;
        s1_bp_d    = s1_bp_q;
        s1_p_d     = s1_p_q;
        s1_g_d     = s1_g_q;
        s1_gp_d    = s1_gp_q;
        s1_gg_d    = s1_gg_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_c0_d = c0_l1;
                s1_a_d  = bus.a;
                s1_bp_d = bp_l1;
                s1_p_d  = p_l1;
                s1_g_d  = g_l1;
                s1_gp_d = gp_l1;
                s1_gg_d = gg_l1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_c0_q    <= 1'b0;
            s1_a_q     <= '0;
            s1_bp_q    <= '0;
            s1_p_q     <= '0;
            s1_g_q     <= '0;
            s1_gp_q    <= '0;
            s1_gg_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_c0_q    <= s1_c0_d;
            s1_a_q     <= s1_a_d;
            s1_bp_q    <= s1_bp_d;
            s1_p_q     <= s1_p_d;
            s1_g_q     <= s1_g_d;
            s1_gp_q    <= s1_gp_d;
            s1_gg_q    <= s1_gg_d;
        end
    end

    assign l2_valid = s1_valid_q;
    assign l2_c0    = s1_c0_q;
    assign l2_a     = s1_a_q;
    assign l2_bp    = s1_bp_q;
    assign l2_p     = s1_p_q;
    assign l2_g     = s1_g_q;
    assign l2_gp    = s1_gp_q;
    assign l2_gg    = s1_gg_q;
`else
    assign in_ready = s1_adv;
    assign l2_valid = bus.in_valid;
    assign l2_c0    = c0_l1;
    assign l2_a     = bus.a;
    assign l2_bp    = bp_l1;
    assign l2_p     = p_l1;
    assign l2_g     = g_l1;
    assign l2_gp    = gp_l1;
    assign l2_gg    = gg_l1;
`endif

    // Second level: every group carry is a flat sum of products over lower groups and c0.
    logic [NGRP:0]    gc;
    logic [WIDTH:0]   c;
    logic             acc, pp;
    logic [WIDTH-1:0] sum_l2;
    logic             cout_l2, ovf_l2;

    always_comb begin
        gc    = '0;
        gc[0] = l2_c0;
        acc   = 1'b0;
        pp    = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            acc = l2_gg[k];
            pp  = l2_gp[k];
            for (int j = k - 1; j >= 0; j--) begin
                acc = acc | (pp & l2_gg[j]);
                pp  = pp & l2_gp[j];
            end
            gc[k+1] = acc | (pp & l2_c0);
        end
        c = '0;
        for (int k = 0; k < NGRP; k++) begin
            c[k*BLOCK] = gc[k];
            for (int i = 1; i < BLOCK; i++) begin
                c[k*BLOCK+i] = l2_g[k*BLOCK+i-1] | (l2_p[k*BLOCK+i-1] & c[k*BLOCK+i-1]);
            end
        end
        c[WIDTH] = gc[NGRP];
        sum_l2   = l2_a ^ l2_bp ^ c[WIDTH-1:0];
        cout_l2  = c[WIDTH];
        ovf_l2   = c[WIDTH] ^ c[WIDTH-1];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (s1_adv) begin
            out_valid_d = l2_valid;
            if (l2_valid) begin
                sum_d  = sum_l2;
                cout_d = cout_l2;
                ovf_d  = ovf_l2;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and streaming bench for cla_pipe_adder at 32/8, 16/4 and 8/8 geometries.
module tb_cla_pipe_adder;
`ifdef CLA_MID_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cla_pipe_adder_if #(.WIDTH(32)) bus32 ();
    cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
    cla_pipe_adder_if #(.WIDTH(8))  bus8 ();

    cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
    cla_pipe_adder #(.WIDTH(8),  .BLOCK(8)) dut8  (.clock(clock), .reset(reset), .bus(bus8));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    function automatic vec_t get_vec(int i);
        vec_t v;
        case (i)
            0:  v = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
            1:  v = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
            2:  v = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
            3:  v = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
            4:  v = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
            5:  v = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
            6:  v = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
            7:  v = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
            8:  v = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
            9:  v = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
            10: v = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [17:0] model16(logic [15:0] a, logic [15:0] b, logic ci, logic s);
        logic [15:0] bb;
        logic [16:0] r;
        logic        ov;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {16'b0, (s | ci)};
        ov = (a[15] == bb[15]) && (r[15] != a[15]);
        return {ov, r[16], r[15:0]};
    endfunction

    function automatic logic [9:0] model8(logic [7:0] a, logic [7:0] b, logic ci, logic s);
        logic [7:0] bb;
        logic [8:0] r;
        logic       ov;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {8'b0, (s | ci)};
        ov = (a[7] == bb[7]) && (r[7] != a[7]);
        return {ov, r[8], r[7:0]};
    endfunction

    task automatic idle_all();
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
        bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus8.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus32.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset out_valid: got %b want 0", bus32.out_valid);
        end
        n_checks++;
        if (bus32.sum !== 32'h0) begin
            n_errors++; $display("FAIL reset sum: got %h want 0", bus32.sum);
        end
        n_checks++;
        if ({bus32.cout, bus32.ovf} !== 2'b00) begin
            n_errors++; $display("FAIL reset flags: got %b want 00", {bus32.cout, bus32.ovf});
        end
        n_checks++;
        if (bus32.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset in_ready: got %b want 1", bus32.in_ready);
        end
        n_checks++;
        if ({bus16.out_valid, bus8.out_valid} !== 2'b00) begin
            n_errors++; $display("FAIL reset small out_valid: got %b want 00", {bus16.out_valid, bus8.out_valid});
        end
    endtask

    task automatic test_vectors();
        vec_t v;
        int   lat;
        for (int i = 0; i < 11; i++) begin
            v = get_vec(i);
            @(negedge clock);
            bus32.a = v.a; bus32.b = v.b; bus32.cin = v.cin; bus32.sub = v.sub;
            bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
            lat = 0;
            do begin
                @(negedge clock);
                bus32.in_valid = 1'b0;
                lat++;
            end while (bus32.out_valid !== 1'b1 && lat < 8);
            n_checks++;
            if (lat != LAT) begin
                n_errors++; $display("FAIL vec[%0d] latency: got %0d want %0d", i, lat, LAT);
            end
            n_checks++;
            if (bus32.sum !== v.s) begin
                n_errors++; $display("FAIL vec[%0d] sum: got %h want %h", i, bus32.sum, v.s);
            end
            n_checks++;
            if (bus32.cout !== v.co) begin
                n_errors++; $display("FAIL vec[%0d] cout: got %b want %b", i, bus32.cout, v.co);
            end
            n_checks++;
            if (bus32.ovf !== v.ov) begin
                n_errors++; $display("FAIL vec[%0d] ovf: got %b want %b", i, bus32.ovf, v.ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] e, av, bv;
        logic        sv;
        int got = 0, first_c = -1, last_c = -1, sent = 0;
        for (int cyc = 0; cyc < 8 + LAT + 4; cyc++) begin
            @(negedge clock);
            bus32.out_ready = 1'b1;
            if (bus32.out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL b2b extra result: got %h want none", bus32.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (bus32.sum !== e) begin
                        n_errors++; $display("FAIL b2b order sum: got %h want %h", bus32.sum, e);
                    end
                end
                got++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            if (sent < 8) begin
                av = 32'h0101_0101 * (sent + 1);
                bv = 32'hFFFF_FF00 ^ 32'(sent);
                sv = sent[0];
                bus32.a = av; bus32.b = bv; bus32.sub = sv; bus32.cin = 1'b0;
                bus32.in_valid = 1'b1;
                #1;
                n_checks++;
                if (bus32.in_ready !== 1'b1) begin
                    n_errors++; $display("FAIL b2b in_ready beat %0d: got %b want 1", sent, bus32.in_ready);
                end
                exp_q.push_back(sv ? av - bv : av + bv);
                sent++;
            end else begin
                bus32.in_valid = 1'b0;
            end
        end
        n_checks++;
        if (got != 8) begin
            n_errors++; $display("FAIL b2b count: got %0d want 8", got);
        end
        n_checks++;
        if (last_c - first_c != 7) begin
            n_errors++; $display("FAIL b2b spacing: got %0d want 7", last_c - first_c);
        end
    endtask

    task automatic test_stall();
        int acc = 0, pop = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            bus32.out_ready = 1'b0;
            if (bus32.out_valid === 1'b1) begin
                n_checks++;
                if (bus32.sum !== 32'h1111_FFFF) begin
                    n_errors++; $display("FAIL stall hold sum: got %h want 1111ffff", bus32.sum);
                end
            end
            bus32.a = 32'h1111_0000 + 32'(acc); bus32.b = 32'h0000_FFFF;
            bus32.sub = 1'b0; bus32.cin = 1'b0; bus32.in_valid = 1'b1;
            #1;
            if (bus32.in_ready === 1'b1) acc++;
        end
        n_checks++;
        if (acc != LAT) begin
            n_errors++; $display("FAIL stall accepts: got %0d want %0d", acc, LAT);
        end
        n_checks++;
        if (bus32.in_ready !== 1'b0) begin
            n_errors++; $display("FAIL stall in_ready: got %b want 0", bus32.in_ready);
        end
        n_checks++;
        if (bus32.out_valid !== 1'b1 || bus32.sum !== 32'h1111_FFFF) begin
            n_errors++; $display("FAIL stall output: got v=%b %h want v=1 1111ffff", bus32.out_valid, bus32.sum);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clock);
            bus32.in_valid = 1'b0;
            bus32.out_ready = 1'b1;
            if (bus32.out_valid === 1'b1) begin
                n_checks++;
                if (bus32.sum !== 32'h1111_FFFF + 32'(pop)) begin
                    n_errors++; $display("FAIL stall drain[%0d]: got %h want %h", pop, bus32.sum, 32'h1111_FFFF + 32'(pop));
                end
                pop++;
            end
        end
        n_checks++;
        if (pop != acc) begin
            n_errors++; $display("FAIL stall drain count: got %0d want %0d", pop, acc);
        end
    endtask

    task automatic test_reset_flight();
        @(negedge clock);
        bus32.out_ready = 1'b0;
        bus32.a = 32'hFFFF_FFF0; bus32.b = 32'h0000_0020; bus32.sub = 1'b0; bus32.cin = 1'b0;
        bus32.in_valid = 1'b1;
        @(negedge clock);
        bus32.a = 32'h0000_0003;
        @(negedge clock);
        bus32.in_valid = 1'b0;
        n_checks++;
        if (bus32.out_valid !== 1'b1 || bus32.sum !== 32'h0000_0010 || bus32.cout !== 1'b1) begin
            n_errors++; $display("FAIL flight pre-reset: got v=%b %h c=%b want v=1 00000010 c=1",
                                 bus32.out_valid, bus32.sum, bus32.cout);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (bus32.out_valid !== 1'b0 || bus32.sum !== 32'h0 || bus32.cout !== 1'b0 || bus32.ovf !== 1'b0) begin
            n_errors++; $display("FAIL flight reset: got v=%b %h c=%b o=%b want all 0",
                                 bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf);
        end
        bus32.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            n_checks++;
            if (bus32.out_valid !== 1'b0) begin
                n_errors++; $display("FAIL flight stale result cycle %0d: got %h want no out_valid", cyc, bus32.sum);
            end
        end
        n_checks++;
        if (bus32.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flight in_ready: got %b want 1", bus32.in_ready);
        end
    endtask

    task automatic test_random_small();
        logic [17:0] q16[$];
        logic [9:0]  q8[$];
        logic [17:0] e16;
        logic [9:0]  e8;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clock);
            if (cyc < 400) begin
                bus16.out_ready = ($urandom_range(0, 3) != 0);
                bus8.out_ready  = ($urandom_range(0, 3) != 0);
            end else begin
                bus16.out_ready = 1'b1;
                bus8.out_ready  = 1'b1;
            end
            if (bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) begin
                n_checks++;
                if (q16.size() == 0) begin
                    n_errors++; $display("FAIL rand16 extra result: got %h want none", bus16.sum);
                end else begin
                    e16 = q16.pop_front();
                    if ({bus16.ovf, bus16.cout, bus16.sum} !== e16) begin
                        n_errors++; $display("FAIL rand16 result: got %h want %h", {bus16.ovf, bus16.cout, bus16.sum}, e16);
                    end
                end
            end
            if (bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
                n_checks++;
                if (q8.size() == 0) begin
                    n_errors++; $display("FAIL rand8 extra result: got %h want none", bus8.sum);
                end else begin
                    e8 = q8.pop_front();
                    if ({bus8.ovf, bus8.cout, bus8.sum} !== e8) begin
                        n_errors++; $display("FAIL rand8 result: got %h want %h", {bus8.ovf, bus8.cout, bus8.sum}, e8);
                    end
                end
            end
            bus16.in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
            bus8.in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
            #1;
            if (bus16.in_valid && bus16.in_ready === 1'b1)
                q16.push_back(model16(bus16.a, bus16.b, bus16.cin, bus16.sub));
            if (bus8.in_valid && bus8.in_ready === 1'b1)
                q8.push_back(model8(bus8.a, bus8.b, bus8.cin, bus8.sub));
        end
        n_checks++;
        if (q16.size() != 0 || q8.size() != 0) begin
            n_errors++; $display("FAIL rand leftover: got %0d/%0d pending want 0/0", q16.size(), q8.size());
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_random_small();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
